// File: rtl/nand_op_sequencer.sv
// Bitwise logic unit built from one reused WIDTH-bit NAND stage, one pass per clock.
// Latency: 1 (NAND, NOT A, illegal), 2 (AND), 3 (OR), 4 (NOR, XOR), 5 (XNOR) cycles from acceptance.
// Backpressure: one op in flight; result held in DONE until out_ready; NAND_SEQ_STATS_EN adds op_count.
module nand_op_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             err
`ifdef NAND_SEQ_STATS_EN
    ,
    output logic [15:0]      op_count
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        DST_NONE,
        DST_T,
        DST_U,
        DST_V
    } dst_t;

    localparam logic [2:0] OP_NAND = 3'd0;
    localparam logic [2:0] OP_AND  = 3'd1;
    localparam logic [2:0] OP_OR   = 3'd2;
    localparam logic [2:0] OP_NOR  = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;
    localparam logic [2:0] OP_NOTA = 3'd6;
    localparam logic [2:0] OP_ILL  = 3'd7;

    state_t           state;
    logic [2:0]       op_q;
    logic [2:0]       pass_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] t_q;
    logic [WIDTH-1:0] u_q;
    logic [WIDTH-1:0] v_q;

    logic [WIDTH-1:0] nand_x;
    logic [WIDTH-1:0] nand_y;
    logic [WIDTH-1:0] nand_dat;
    dst_t             dst;
    logic             last_pass;
    logic             illegal;

    // Per-opcode pass schedule: which operands feed the NAND stage and where the result lands.
    // NOR/XNOR park the intermediate OR/XOR result in V/T, then invert it on the extra pass.
    always_comb begin
        nand_x    = '0;
        nand_y    = '0;
        dst       = DST_NONE;
        last_pass = 1'b0;
        case (op_q)
            OP_NAND: begin
                nand_x    = a_q;
                nand_y    = b_q;
                last_pass = 1'b1;
            end
            OP_NOTA: begin
                nand_x    = a_q;
                nand_y    = a_q;
                last_pass = 1'b1;
            end
            OP_AND: begin
                if (pass_q == 3'd0) begin
                    nand_x = a_q;
                    nand_y = b_q;
                    dst    = DST_T;
                end else begin
                    nand_x    = t_q;
                    nand_y    = t_q;
                    last_pass = 1'b1;
                end
            end
            OP_OR, OP_NOR: begin
                case (pass_q)
                    3'd0: begin
                        nand_x = a_q;
                        nand_y = a_q;
                        dst    = DST_T;
                    end
                    3'd1: begin
                        nand_x = b_q;
                        nand_y = b_q;
                        dst    = DST_U;
                    end
                    3'd2: begin
                        nand_x    = t_q;
                        nand_y    = u_q;
                        dst       = DST_V;
                        last_pass = (op_q == OP_OR);
                    end
                    default: begin
                        nand_x    = v_q;
                        nand_y    = v_q;
                        last_pass = 1'b1;
                    end
                endcase
            end
            OP_XOR, OP_XNOR: begin
                case (pass_q)
                    3'd0: begin
                        nand_x = a_q;
                        nand_y = b_q;
                        dst    = DST_T;
                    end
                    3'd1: begin
                        nand_x = a_q;
                        nand_y = t_q;
                        dst    = DST_U;
                    end
                    3'd2: begin
                        nand_x = b_q;
                        nand_y = t_q;
                        dst    = DST_V;
                    end
                    3'd3: begin
                        nand_x    = u_q;
                        nand_y    = v_q;
                        dst       = DST_T;
                        last_pass = (op_q == OP_XOR);
                    end
                    default: begin
                        nand_x    = t_q;
                        nand_y    = t_q;
                        last_pass = 1'b1;
                    end
                endcase
            end
            default: begin
                last_pass = 1'b1;
            end
        endcase
    end

    assign nand_dat = ~(nand_x & nand_y);
    assign illegal  = (op_q == OP_ILL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            err       <= 1'b0;
            op_q      <= '0;
            pass_q    <= '0;
            a_q       <= '0;
            b_q       <= '0;
            t_q       <= '0;
            u_q       <= '0;
            v_q       <= '0;
`ifdef NAND_SEQ_STATS_EN
            op_count  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= a;
                        b_q      <= b;
                        op_q     <= op;
                        pass_q   <= '0;
                        in_ready <= 1'b0;
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    case (dst)
                        DST_T:   t_q <= nand_dat;
                        DST_U:   u_q <= nand_dat;
                        DST_V:   v_q <= nand_dat;
                        default: ;
                    endcase
                    pass_q <= pass_q + 3'd1;
                    if (last_pass) begin
                        result    <= illegal ? '0 : nand_dat;
                        err       <= illegal;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
`ifdef NAND_SEQ_STATS_EN
                        op_count  <= op_count + 16'd1;
`endif
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
